// File: rtl/ysyx_25020037_axi_sram_slave.sv
`default_nettype none
// ysyx_25020037_axi_sram_slave: AXI4 subordinate in front of a word-organised SRAM.
// One transaction in flight; reads win arbitration; fixed response latency.
module ysyx_25020037_axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hA0000000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int IDXW = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_DATA = 3'd3,
    S_WR_WAIT = 3'd4,
    S_WR_RESP = 3'd5
  } state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_addr,  w_addr_nx;
  logic [7:0]  r_len,   w_len_nx;
  logic [7:0]  r_beat,  w_beat_nx;
  logic [7:0]  r_cnt,   w_cnt_nx;
  logic        r_incr,  w_incr_nx;
  logic        r_bad,   w_bad_nx;
  logic        r_werr,  w_werr_nx;
  logic [3:0]  r_rid,   w_rid_nx;
  logic [3:0]  r_bid,   w_bid_nx;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [29:0]     w_woff;
  logic [IDXW-1:0] w_idx;
  logic            w_beat_err;
  logic            w_last_beat;
  logic [31:0]     w_next_addr;
  logic            w_we;

  // Subtracting below the base wraps to a huge offset, so one compare covers both bounds.
  assign w_woff      = r_addr[31:2] - BASE_ADDR[31:2];
  assign w_idx       = w_woff[IDXW-1:0];
  assign w_beat_err  = (w_woff >= 30'(DEPTH_WORDS)) | r_bad;
  assign w_last_beat = (r_beat == r_len);
  assign w_next_addr = r_incr ? (r_addr + 32'd4) : r_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
      r_incr  <= 1'b0;
      r_bad   <= 1'b0;
      r_werr  <= 1'b0;
      r_rid   <= '0;
      r_bid   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_len   <= w_len_nx;
      r_beat  <= w_beat_nx;
      r_cnt   <= w_cnt_nx;
      r_incr  <= w_incr_nx;
      r_bad   <= w_bad_nx;
      r_werr  <= w_werr_nx;
      r_rid   <= w_rid_nx;
      r_bid   <= w_bid_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_len_nx   = r_len;
    w_beat_nx  = r_beat;
    w_cnt_nx   = r_cnt;
    w_incr_nx  = r_incr;
    w_bad_nx   = r_bad;
    w_werr_nx  = r_werr;
    w_rid_nx   = r_rid;
    w_bid_nx   = r_bid;
    case (r_state)
      S_IDLE: begin
        if (arvalid) begin
          w_addr_nx  = araddr;
          w_len_nx   = arlen;
          w_beat_nx  = '0;
          w_incr_nx  = (arburst == 2'b01);
          w_bad_nx   = (arsize != 3'd2) | arburst[1];
          w_rid_nx   = arid;
          w_cnt_nx   = 8'(LATENCY);
          w_state_nx = S_RD_WAIT;
        end else if (awvalid) begin
          w_addr_nx  = awaddr;
          w_len_nx   = awlen;
          w_beat_nx  = '0;
          w_incr_nx  = (awburst == 2'b01);
          w_bad_nx   = (awsize != 3'd2) | awburst[1];
          w_bid_nx   = awid;
          w_werr_nx  = 1'b0;
          w_state_nx = S_WR_DATA;
        end
      end
      S_RD_WAIT: begin
        if (r_cnt <= 8'd1) w_state_nx = S_RD_DATA;
        else               w_cnt_nx   = r_cnt - 8'd1;
      end
      S_RD_DATA: begin
        if (rready) begin
          if (w_last_beat) begin
            w_state_nx = S_IDLE;
          end else begin
            w_beat_nx = r_beat + 8'd1;
            w_addr_nx = w_next_addr;
          end
        end
      end
      S_WR_DATA: begin
        if (wvalid) begin
          // The beat count, not wlast, ends the burst; a wlast disagreement only poisons the response.
          w_werr_nx = r_werr | w_beat_err | (wlast != w_last_beat);
          if (w_last_beat) begin
            w_cnt_nx   = 8'(LATENCY);
            w_state_nx = S_WR_WAIT;
          end else begin
            w_beat_nx = r_beat + 8'd1;
            w_addr_nx = w_next_addr;
          end
        end
      end
      S_WR_WAIT: begin
        if (r_cnt <= 8'd1) w_state_nx = S_WR_RESP;
        else               w_cnt_nx   = r_cnt - 8'd1;
      end
      S_WR_RESP: begin
        if (bready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_we = (r_state == S_WR_DATA) & wvalid & ~w_beat_err;

  // Contents deliberately have no reset so they survive a bus reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign arready = rst & (r_state == S_IDLE);
  assign awready = rst & (r_state == S_IDLE) & ~arvalid;
  assign wready  = (r_state == S_WR_DATA);
  assign rvalid  = (r_state == S_RD_DATA);
  assign rdata   = (rvalid & ~w_beat_err) ? r_mem[w_idx] : 32'd0;
  assign rresp   = (rvalid & w_beat_err) ? 2'b10 : 2'b00;
  assign rlast   = rvalid & w_last_beat;
  assign rid     = r_rid;
  assign bvalid  = (r_state == S_WR_RESP);
  assign bresp   = (bvalid & r_werr) ? 2'b10 : 2'b00;
  assign bid     = r_bid;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020037_axi_sram_slave.sv
`default_nettype none
// tb_ysyx_25020037_axi_sram_slave: directed AXI traffic against a transaction-level memory model.
module tb_ysyx_25020037_axi_sram_slave;

  localparam logic [31:0] BASE  = 32'hA0000000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;

  ysyx_25020037_axi_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] d; logic [1:0] resp; logic last; logic [3:0] id;} rexp_t;
  typedef struct packed {logic [1:0] resp; logic [3:0] id;} bexp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_r_cyc = -10;
  int          aw_cyc = -10;
  bit          rd_active = 1'b0;
  logic [31:0] mm [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  rexp_t       r_q[$];
  bexp_t       b_q[$];
  logic [31:0] cap_d[$];
  logic [1:0]  cap_r[$];
  logic        cap_l[$];
  logic [3:0]  cap_id[$];
  logic [1:0]  last_bresp;
  logic [3:0]  last_bid;
  rexp_t       re;
  bexp_t       be;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic bit m_err(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bu);
    longint off;
    off = longint'({32'd0, a}) - longint'({32'd0, BASE});
    return (off < 0) || (off >= 4 * DEPTH) || (sz != 3'd2) || bu[1];
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    logic [31:0] t;
    t = a - BASE;
    return int'(t >> 2);
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [1:0] bu, input int k);
    return (bu == 2'b01) ? a + 32'(4 * k) : a;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: every cycle a response channel is valid it must match the model's next entry.
  always @(negedge clk) begin
    if (!rst) begin
      r_q.delete();
      b_q.delete();
      rd_active = 1'b0;
    end else begin
      if (arvalid) chk("awready_prio", awready, 1'b0);
      if (rd_active) chk("awready_busy", awready, 1'b0);
      if (arvalid && arready) rd_active = 1'b1;
      if (awvalid && awready) aw_cyc = cyc;
      if (rvalid) begin
        if (r_q.size() == 0) fail("r_unexpected");
        else begin
          re = r_q[0];
          chk("rdata", rdata, re.d);
          chk("rresp", rresp, re.resp);
          chk("rlast", rlast, re.last);
          chk("rid", rid, re.id);
          if (rready) begin
            void'(r_q.pop_front());
            cap_d.push_back(rdata);
            cap_r.push_back(rresp);
            cap_l.push_back(rlast);
            cap_id.push_back(rid);
            if (rlast) begin
              rd_active = 1'b0;
              last_r_cyc = cyc;
            end
          end
        end
      end
      if (bvalid) begin
        if (b_q.size() == 0) fail("b_unexpected");
        else begin
          be = b_q[0];
          chk("bresp", bresp, be.resp);
          chk("bid", bid, be.id);
          if (bready) begin
            void'(b_q.pop_front());
            last_bresp = bresp;
            last_bid   = bid;
          end
        end
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu,
                           input logic [2:0] sz, input logic [3:0] id, input int bad_last);
    bit err;
    bit bek;
    bit wl;
    int n;
    logic [31:0] ba;
    err = 1'b0;
    awaddr = a; awlen = len; awburst = bu; awsize = sz; awid = id; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 200);
    if (!awready) begin fail("aw_timeout"); awvalid = 1'b0; return; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      ba  = m_addr(a, bu, k);
      bek = m_err(ba, sz, bu);
      wl  = (k == int'(len)) || (k == bad_last);
      if (bek || (wl != (k == int'(len)))) err = 1'b1;
      wvalid = 1'b1; wdata = wd[k]; wstrb = ws[k]; wlast = wl;
      n = 0;
      do begin @(negedge clk); n++; end while (!wready && n < 200);
      if (!wready) begin fail("w_timeout"); wvalid = 1'b0; return; end
      @(posedge clk); #1;
      if (!bek) begin
        for (int b = 0; b < 4; b++)
          if (ws[k][b]) mm[m_idx(ba)][8*b +: 8] = wd[k][8*b +: 8];
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    b_q.push_back({err ? 2'b10 : 2'b00, id});
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 300);
    if (!bvalid) begin fail("b_timeout"); return; end
    chk("wr_latency", 64'(n - 1), 64'(LAT));
    @(posedge clk); #1;
    bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu,
                          input logic [2:0] sz, input logic [3:0] id, input bit tog, input int abort_at);
    int n;
    int done;
    bit seen;
    bit er;
    rexp_t e;
    logic [31:0] ba;
    araddr = a; arlen = len; arburst = bu; arsize = sz; arid = id; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 200);
    if (!arready) begin fail("ar_timeout"); arvalid = 1'b0; return; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      ba     = m_addr(a, bu, k);
      er     = m_err(ba, sz, bu);
      e.d    = er ? 32'd0 : mm[m_idx(ba)];
      e.resp = er ? 2'b10 : 2'b00;
      e.last = (k == int'(len));
      e.id   = id;
      r_q.push_back(e);
    end
    rready = tog ? 1'b0 : 1'b1;
    n = 0; done = 0; seen = 1'b0;
    while (done <= int'(len) && n < 1000) begin
      @(negedge clk); n++;
      if (rvalid && !seen) begin
        seen = 1'b1;
        chk("rd_latency", 64'(n - 1), 64'(LAT));
      end
      if (rvalid && rready) done++;
      @(posedge clk); #1;
      if (abort_at >= 0 && done == abort_at) begin
        rst = 1'b0;
        rready = 1'b0;
        #1;
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_arready", arready, 1'b0);
        return;
      end
      if (tog) rready = ~rready;
    end
    rready = 1'b0;
    if (done <= int'(len)) fail("rd_timeout");
  endtask

  task automatic clr_cap();
    cap_d.delete(); cap_r.delete(); cap_l.delete(); cap_id.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01; rready = 0;
    repeat (3) @(posedge clk);
    #1;
    arvalid = 1'b1; awvalid = 1'b1;
    #1;
    chk("rst_arready0", arready, 1'b0);
    chk("rst_awready0", awready, 1'b0);
    arvalid = 1'b0; awvalid = 1'b0;
    chk("rst_wready", wready, 1'b0);
    chk("rst_rvalid0", rvalid, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", rresp, 2'd0);
    chk("rst_bresp", bresp, 2'd0);
    chk("rst_rid", rid, 4'd0);
    chk("rst_bid", bid, 4'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_arready", arready, 1'b1);
    chk("idle_awready", awready, 1'b1);
    @(posedge clk); #1;

    // Single write then single read
    wd[0] = 32'h12345678; ws[0] = 4'hF;
    axi_write(32'hA0000000, 8'd0, 2'b01, 3'd2, 4'd1, -1);
    chk("t1_bresp", last_bresp, 2'b00);
    chk("t1_bid", last_bid, 4'd1);
    clr_cap();
    axi_read(32'hA0000000, 8'd0, 2'b01, 3'd2, 4'd3, 1'b0, -1);
    chk("t1_rdata", cap_d[0], 32'h12345678);
    chk("t1_rresp", cap_r[0], 2'b00);
    chk("t1_rlast", cap_l[0], 1'b1);
    chk("t1_rid", cap_id[0], 4'd3);

    // Byte strobe
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    axi_write(32'hA0000004, 8'd0, 2'b01, 3'd2, 4'd2, -1);
    wd[0] = 32'h00AB0000; ws[0] = 4'b0100;
    axi_write(32'hA0000004, 8'd0, 2'b01, 3'd2, 4'd2, -1);
    chk("strb_bresp", last_bresp, 2'b00);
    clr_cap();
    axi_read(32'hA0000004, 8'd0, 2'b01, 3'd2, 4'd4, 1'b0, -1);
    chk("strb_rdata", cap_d[0], 32'hFFABFFFF);

    // INCR burst with rready toggling
    for (int i = 0; i < 8; i++) begin wd[i] = 32'(i); ws[i] = 4'hF; end
    axi_write(32'hA0000000, 8'd7, 2'b01, 3'd2, 4'd5, -1);
    clr_cap();
    axi_read(32'hA0000000, 8'd7, 2'b01, 3'd2, 4'd6, 1'b1, -1);
    chk("incr_beats", 64'(cap_d.size()), 64'd8);
    for (int i = 0; i < 8 && i < cap_d.size(); i++) begin
      chk("incr_rdata", cap_d[i], 32'(i));
      chk("incr_rlast", cap_l[i], (i == 7) ? 1'b1 : 1'b0);
    end

    // Out-of-range read below the base
    clr_cap();
    axi_read(32'h9FFFFFFC, 8'd0, 2'b01, 3'd2, 4'd7, 1'b0, -1);
    chk("oob_rd_data", cap_d[0], 32'd0);
    chk("oob_rd_resp", cap_r[0], 2'b10);

    // Out-of-range write must not alias onto word 0
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(32'hA0001000, 8'd0, 2'b01, 3'd2, 4'd8, -1);
    chk("oob_wr_bresp", last_bresp, 2'b10);
    clr_cap();
    axi_read(32'hA0000000, 8'd0, 2'b01, 3'd2, 4'd9, 1'b0, -1);
    chk("oob_wr_word0", cap_d[0], 32'd0);

    // Early wlast: all beats still accepted, response poisoned
    for (int i = 0; i < 8; i++) begin wd[i] = 32'h100 + 32'(i); ws[i] = 4'hF; end
    axi_write(32'hA0000020, 8'd7, 2'b01, 3'd2, 4'd10, 3);
    chk("wlast_bresp", last_bresp, 2'b10);
    clr_cap();
    axi_read(32'hA0000020, 8'd7, 2'b01, 3'd2, 4'd11, 1'b0, -1);
    chk("wlast_beat3", cap_d[3], 32'h103);

    // FIXED burst merges strobed bytes into one word
    wd[0] = 32'h11111111; ws[0] = 4'b0001;
    wd[1] = 32'h22222222; ws[1] = 4'b0010;
    wd[2] = 32'h33333333; ws[2] = 4'b0100;
    wd[3] = 32'h44444444; ws[3] = 4'b1000;
    wd[4] = 32'hFFFFFFFF; ws[4] = 4'hF;
    axi_write(32'hA0000044, 8'd0, 2'b01, 3'd2, 4'd12, -1);
    axi_write(32'hA0000040, 8'd3, 2'b00, 3'd2, 4'd12, -1);
    clr_cap();
    axi_read(32'hA0000040, 8'd1, 2'b00, 3'd2, 4'd13, 1'b0, -1);
    chk("fixed_b0", cap_d[0], 32'h44332211);
    chk("fixed_b1", cap_d[1], 32'h44332211);

    // Bad size is an error on every beat
    clr_cap();
    axi_read(32'hA0000000, 8'd0, 2'b01, 3'd1, 4'd14, 1'b0, -1);
    chk("size_resp", cap_r[0], 2'b10);

    // Simultaneous AR and AW: read first, write in the first free IDLE cycle
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    fork
      axi_read(32'hA0000000, 8'd2, 2'b01, 3'd2, 4'd5, 1'b0, -1);
      axi_write(32'hA0000060, 8'd0, 2'b01, 3'd2, 4'd6, -1);
    join
    chk("arb_aw_cycle", 64'(aw_cyc), 64'(last_r_cyc + 1));
    chk("arb_bid", last_bid, 4'd6);

    // Reset during beat 4 of an 8-beat read
    axi_read(32'hA0000020, 8'd7, 2'b01, 3'd2, 4'd7, 1'b0, 3);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    clr_cap();
    axi_read(32'hA0000020, 8'd0, 2'b01, 3'd2, 4'd2, 1'b0, -1);
    chk("post_rst_rdata", cap_d[0], 32'h100);
    chk("post_rst_rid", cap_id[0], 4'd2);
    clr_cap();
    axi_read(32'hA0000060, 8'd0, 2'b01, 3'd2, 4'd1, 1'b0, -1);
    chk("post_rst_arbw", cap_d[0], 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    chk("r_q_drained", 64'(r_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
